// File: rtl/bus_sequencer.sv
// Sequencer for single-word moves over a shared tristate bus between registers,
// or from an immediate value into a register, with ordered CS/WE/OE strobes.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bus_sequencer #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic [ADDR_WIDTH-1:0]        src,
  input  logic [ADDR_WIDTH-1:0]        dst,
  input  logic                         imm_en,
  input  logic [DATA_WIDTH-1:0]        imm_data,
  output logic                         busy,
  output logic                         done,
  output logic [(1<<ADDR_WIDTH)-1:0]   cs,
  output logic [(1<<ADDR_WIDTH)-1:0]   we,
  output logic [(1<<ADDR_WIDTH)-1:0]   oe,
  inout  wire  [DATA_WIDTH-1:0]        data,
  output logic [2:0]                   fsm_state
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic                  imm_en_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic                  src_active;
  logic                  dst_active;
  logic                  imm_drive;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && req) begin
        src_q    <= src;
        dst_q    <= dst;
        imm_en_q <= imm_en;
        imm_q    <= imm_data;
      end
    end
  end

  // A register-to-itself move is a no-op: skip straight to DONE with no strobes.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (!imm_en && (src == dst)) state_next = S_DONE;
          else                         state_next = S_DRIVE;
        end
      end
      S_DRIVE: state_next = S_WRITE;
      S_WRITE: state_next = S_HOLD;
      S_HOLD:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Source drives across DRIVE..HOLD; destination WE only in WRITE, so the
  // destination closes a full cycle before the source lets go of the bus.
  always_comb begin
    src_active = (state == S_DRIVE) || (state == S_WRITE) || (state == S_HOLD);
    dst_active = (state == S_WRITE);
    imm_drive  = src_active && imm_en_q;
    oe         = (src_active && !imm_en_q) ? (NUM_REGS'(1) << src_q) : '0;
    we         = dst_active ? (NUM_REGS'(1) << dst_q) : '0;
    cs         = oe | we;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    fsm_state  = state;
  end

  assign data = imm_drive ? imm_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: behavioural register array on the bus, per-cycle
// expected strobe trace built from the transfer rules, randomized transfers.
`timescale 1ns/1ps

module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic [1:0] src = '0;
  logic [1:0] dst = '0;
  logic       imm_en = 1'b0;
  logic [7:0] imm_data = '0;
  logic       busy;
  logic       done;
  logic [3:0] cs;
  logic [3:0] we;
  logic [3:0] oe;
  wire  [7:0] data;
  logic [2:0] fsm_state;

  int compared = 0;
  int mismatched = 0;
  int xfer_id = 0;

  logic [7:0] regs [4];
  logic [7:0] mem  [4];
  bit         known[4];

  // Clock / reset
  always #5 clk = ~clk;

  bus_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .src       (src),
    .dst       (dst),
    .imm_en    (imm_en),
    .imm_data  (imm_data),
    .busy      (busy),
    .done      (done),
    .cs        (cs),
    .we        (we),
    .oe        (oe),
    .data      (data),
    .fsm_state (fsm_state)
  );

  // Bus-attached register array: captures on an edge with CS&WE, drives on CS&OE.
  logic [7:0] reg_bus;
  logic       reg_drive;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (cs[i] && we[i]) regs[i] <= data;
  end

  always_comb begin
    reg_drive = 1'b0;
    reg_bus   = 8'h00;
    for (int i = 0; i < 4; i++)
      if (cs[i] && oe[i]) begin
        reg_drive = 1'b1;
        reg_bus   = regs[i];
      end
  end

  assign data = reg_drive ? reg_bus : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Contention monitor: at most one bus driver, never OE and WE on one register.
  int drivers;
  always @(negedge clk) begin
    if (reset) begin
      drivers = $countones(oe) + (dut.imm_drive ? 1 : 0);
      check("one_driver", 32'(drivers <= 1), 32'd1);
      check("oe_we_overlap", 32'(oe & we), 32'd0);
    end
  end

  // Driver + scoreboard: expected per-cycle trace packed as
  // {busy, done, imm_drive, cs[3:0], we[3:0], oe[3:0]}.
  task automatic run_xfer(input logic [1:0] s, input logic [1:0] d, input logic ie,
                          input logic [7:0] iv, input bit hold, input bit pulse);
    logic [14:0] exp_q[$];
    logic [14:0] e;
    logic [3:0]  oe_e;
    logic [3:0]  we_e;
    bit          noop;
    bit          src_on;
    bit          pulse_eff;
    int          n;
    int          cyc;
    string       tag;

    noop      = !ie && (s == d);
    n         = noop ? 1 : 4;
    pulse_eff = pulse && !noop;
    for (int k = 1; k <= n; k++) begin
      src_on = !noop && (k <= 3);
      oe_e   = (src_on && !ie) ? 4'(1 << s) : 4'd0;
      we_e   = (!noop && k == 2) ? 4'(1 << d) : 4'd0;
      exp_q.push_back({1'b1, 1'(k == n), 1'(src_on && ie), oe_e | we_e, we_e, oe_e});
    end
    exp_q.push_back(15'd0);
    if (pulse_eff) exp_q.push_back(15'd0);

    src = s; dst = d; imm_en = ie; imm_data = iv; req = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++;
      tag = $sformatf("x%0d_c%0d", xfer_id, cyc);
      check({tag, "_busy"}, 32'(busy), 32'(e[14]));
      check({tag, "_done"}, 32'(done), 32'(e[13]));
      check({tag, "_imm"}, 32'(dut.imm_drive), 32'(e[12]));
      check({tag, "_cs"}, 32'(cs), 32'(e[11:8]));
      check({tag, "_we"}, 32'(we), 32'(e[7:4]));
      check({tag, "_oe"}, 32'(oe), 32'(e[3:0]));
      if (e[12]) check({tag, "_data"}, 32'(data), 32'(iv));
      if (cyc == 1) begin
        src = 2'($urandom_range(0, 3)); dst = 2'($urandom_range(0, 3));
        imm_en = 1'($urandom_range(0, 1)); imm_data = 8'($urandom_range(0, 255));
      end
      req = (hold && cyc < n) || (pulse_eff && cyc == 2);
    end

    if (!noop) begin
      if (ie) begin
        mem[d] = iv; known[d] = 1'b1;
      end else begin
        mem[d] = mem[s]; known[d] = known[s];
      end
    end
    for (int i = 0; i < 4; i++)
      if (known[i]) check($sformatf("x%0d_reg%0d", xfer_id, i), 32'(regs[i]), 32'(mem[i]));
    xfer_id++;
  endtask

  initial begin
    // Reset state before any clock edge
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_strobes", 32'({cs, we, oe}), 32'd0);
    check("rst_imm", 32'(dut.imm_drive), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Preload every register by immediate load (imm with src==dst is not a no-op)
    run_xfer(2'd0, 2'd0, 1'b1, 8'h77, 1'b0, 1'b0);
    run_xfer(2'd0, 2'd1, 1'b1, 8'h3C, 1'b0, 1'b0);
    run_xfer(2'd0, 2'd2, 1'b1, 8'hA5, 1'b0, 1'b0);
    run_xfer(2'd1, 2'd3, 1'b1, 8'hC3, 1'b0, 1'b0);
    // Register move reg1 -> reg3
    run_xfer(2'd1, 2'd3, 1'b0, 8'hEE, 1'b0, 1'b0);
    // No-op reg0 -> reg0
    run_xfer(2'd0, 2'd0, 1'b0, 8'hEE, 1'b0, 1'b0);
    // Back-to-back: held req, then a move with a req pulse while busy
    run_xfer(2'd3, 2'd0, 1'b1, 8'h11, 1'b1, 1'b0);
    run_xfer(2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-WRITE aborts asynchronously
    src = 2'd0; dst = 2'd2; imm_en = 1'b1; imm_data = 8'h5F; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_strobes", 32'({cs, we, oe}), 32'd0);
    check("arst_imm", 32'(dut.imm_drive), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    known[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("post_rst%0d_done", i), 32'(done), 32'd0);
    end
    run_xfer(2'd1, 2'd2, 1'b1, 8'h42, 1'b0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      logic [1:0] rs;
      logic [1:0] rd;
      logic       rie;
      bit         rh;
      bit         rp;
      rs  = 2'($urandom_range(0, 3));
      rd  = 2'($urandom_range(0, 3));
      rie = ($urandom_range(0, 2) == 0);
      rh  = 1'($urandom_range(0, 1));
      rp  = !rh && ($urandom_range(0, 3) == 0);
      run_xfer(rs, rd, rie, 8'($urandom_range(0, 255)), rh, rp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Control sequencer that moves one word per request across the shared tristate data bus between bus-attached registers, or from an immediate value into a register. It sits directly upstream of the register array: it generates each register's CS/WE/OE strobes and, for immediate loads, drives the bus itself. Strobe timing is ordered so the destination's transparent latch closes before the source releases the bus.

## Interface
- `DATA_WIDTH`, default `DATA_WIDTH` macro value (8): bus width.
- `ADDR_WIDTH`, default 2: register select width; `NUM_REGS = 1 << ADDR_WIDTH` (4).
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `req`  input  1  transfer request; sampled only in IDLE.
- `src`  input  ADDR_WIDTH  source register index; ignored when `imm_en`=1.
- `dst`  input  ADDR_WIDTH  destination register index.
- `imm_en`  input  1  1 = source is `imm_data`, not a register.
- `imm_data`  input  DATA_WIDTH  immediate value.
- `busy`  output  1  high from the cycle after acceptance through the DONE cycle.
- `done`  output  1  one-cycle pulse when the transfer completes.
- `cs`  output  NUM_REGS  per-register chip select.
- `we`  output  NUM_REGS  per-register write enable.
- `oe`  output  NUM_REGS  per-register output enable.
- `data`  inout  DATA_WIDTH  shared bus; driven by this block only in immediate transfers, high-Z otherwise.

## Operation
- States: IDLE, DRIVE, WRITE, HOLD, DONE. All outputs decoded from registered state and captured fields (no combinational path from inputs to strobes).
- IDLE: all strobes 0, bus released, `busy`=0. On an edge with `req`=1: capture `src`, `dst`, `imm_en`, `imm_data`; go to DRIVE. If captured `src`==`dst` and `imm_en`=0, go directly to DONE (no-op, no strobes).
- DRIVE: source active, `cs[src]`=1, `oe[src]`=1 (or `data`=`imm_data` if immediate). Bus settles.
- WRITE: source still active; additionally `cs[dst]`=1, `we[dst]`=1. Destination flop captures the bus on the edge leaving WRITE.
- HOLD: `we[dst]`=0 (latch closes), `cs[dst]`=0; source still driving.
- DONE: all strobes 0, bus released, `done`=1, `busy`=1; next state IDLE unconditionally.
- `cs` is the OR of the one-hot source and destination enables; `oe` is only ever set on the source, `we` only on the destination; never both on the same index.
- `req` during DRIVE/WRITE/HOLD/DONE is ignored (not queued); requester must hold `req` until `done` or re-assert afterwards.
- At most one bus driver at any time: immediate drive and register `oe` are mutually exclusive.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, `cs`=`we`=`oe`=0, `busy`=0, `done`=0, `data`=high-Z immediately, without waiting for a clock edge. Reset mid-transfer aborts; destination contents are unspecified.
- Normal transfer: `req` sampled at edge 0; DRIVE cycle 1, WRITE cycle 2, HOLD cycle 3, DONE cycle 4 (`done`=1); back in IDLE at cycle 5. New request may be accepted at the edge ending cycle 5 (i.e. sampled in IDLE), so throughput is one transfer per 5 cycles.
- No-op (src==dst, register source): DONE in cycle 1, IDLE in cycle 2.
- Destination value visible on its Q after the edge ending WRITE (start of HOLD).
- Source drive spans cycles 1-3; destination `we` spans cycle 2 only, so `we` falls one full cycle before source release.

## Test plan
- Reset: assert reset=0 mid-WRITE -> strobes 0, `data` high-Z, `busy`=0 same cycle; after release IDLE, no `done`.
- Immediate load: `imm_en`=1, `imm_data`=8'hA5, `dst`=2 -> `we[2]` high cycle 2 only, `done` cycle 4, reg2 reads 8'hA5.
- Register move: preload reg1=8'h3C, `src`=1, `dst`=3 -> `oe[1]` cycles 1-3, `we[3]` cycle 2, reg3=8'h3C, reg1 unchanged.
- No-op: `src`=`dst`=0 -> no strobes, `done` in cycle 1, reg0 unchanged.
- Back-to-back with held `req`: two requests (imm 8'h11 -> reg0, then reg0 -> reg1) -> second accepted in IDLE after first `done`; reg1=8'h11; `req` pulse during busy is dropped.
- Bus contention check every cycle: never more than one of {immediate drive, any `oe`} active; `oe[i]`&`we[i]` never 1.
